mem_stage_lsu: RTL

- Load/store unit for the MEM stage. Consumes the EX/MEM pipeline register outputs: address, store data, funct3, MemWrite and ResultSrc.
- Drives a valid/ready data-memory bus, generates byte enables and store-data lane placement, and sign/zero-extends load data.
- Holds the pipeline with StallM until the bus access completes; flags misaligned or illegal accesses.

---
 rtl/mem_stage_lsu.sv | 100 ++++++++++
 1 files changed

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit driving a valid/ready data bus, stalling the pipeline per access.
// Optional bus watchdog enabled by defining LSU_TIMEOUT_EN.
module mem_stage_lsu #(
    parameter int XLEN = 32,
    parameter logic [2:0] LOAD_SRC = 3'b001
`ifdef LSU_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            MemWriteM,
    input  logic [2:0]      ResultSrcM,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] WriteDataM,
    input  logic [2:0]      funct3M,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [XLEN-1:0] ReadDataM,
    output logic            StallM,
    output logic            MemFaultM
);
    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
    state_t state, state_n;
    logic [2:0] f3_q;
    logic [1:0] lane_q;
    logic load, access, legal, mis, fault, go, bus_end, timeout, fault_q;
    logic [3:0] be_n;
    logic [7:0] rd_b;
    logic [15:0] rd_h;
    logic [XLEN-1:0] wdata_n, ext;
`ifdef LSU_TIMEOUT_EN
    logic [4:0] wd_cnt;
    assign timeout = state == BUS && !dmem_ready && wd_cnt == 5'(TIMEOUT_CYCLES - 1);
    // Counter is held at zero outside BUS, so it is clear on every BUS entry.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wd_cnt <= '0;
            fault_q <= 1'b0;
        end else begin
            wd_cnt <= state != BUS ? 5'd0 : !dmem_ready ? wd_cnt + 5'd1 : wd_cnt;
            fault_q <= timeout;
        end
`else
    assign timeout = 1'b0;
    assign fault_q = 1'b0;
`endif
    always_comb begin
        load = ResultSrcM == LOAD_SRC;
        access = load || MemWriteM;
        legal = MemWriteM ? funct3M inside {3'b000, 3'b001, 3'b010}
                          : funct3M inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        mis = (funct3M[1:0] == 2'b01 && ALUResultM[0]) || (funct3M[1:0] == 2'b10 && ALUResultM[1:0] != 2'b00);
        fault = access && (!legal || mis);
        go = access && !fault;
        be_n = funct3M[1:0] == 2'b00 ? 4'b0001 << ALUResultM[1:0] :
               funct3M[1:0] == 2'b01 ? 4'b0011 << ALUResultM[1:0] : 4'b1111;
        wdata_n = funct3M[1:0] == 2'b00 ? {4{WriteDataM[7:0]}} :
                  funct3M[1:0] == 2'b01 ? {2{WriteDataM[15:0]}} : WriteDataM;
        rd_b = dmem_rdata[{lane_q, 3'b000} +: 8];
        rd_h = dmem_rdata[{lane_q[1], 4'b0000} +: 16];
        ext = f3_q[1:0] == 2'b00 ? {{(XLEN-8){!f3_q[2] && rd_b[7]}}, rd_b} :
              f3_q[1:0] == 2'b01 ? {{(XLEN-16){!f3_q[2] && rd_h[15]}}, rd_h} : dmem_rdata;
        bus_end = dmem_ready || timeout;
        state_n = state == IDLE ? (go ? BUS : IDLE) :
                  state == BUS ? (bus_end ? DONE : BUS) : IDLE;
        StallM = !reset && (state == BUS || (state == IDLE && go));
        MemFaultM = !reset && ((state == IDLE && fault) || (state == DONE && fault_q));
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_n;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            dmem_req <= 1'b0;
            dmem_we <= 1'b0;
            dmem_addr <= '0;
            dmem_be <= '0;
            dmem_wdata <= '0;
            ReadDataM <= '0;
            f3_q <= '0;
            lane_q <= '0;
        end else if (state == IDLE && go) begin
            dmem_req <= 1'b1;
            dmem_we <= MemWriteM;
            dmem_addr <= {ALUResultM[XLEN-1:2], 2'b00};
            dmem_be <= be_n;
            dmem_wdata <= wdata_n;
            f3_q <= funct3M;
            lane_q <= ALUResultM[1:0];
        end else if (state == BUS && bus_end) begin
            dmem_req <= 1'b0;
            if (!dmem_we) ReadDataM <= dmem_ready ? ext : '0;
        end
endmodule
